// File: rtl/tx_ethernet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_ethernet_arbiter
// Purpose  : Shares one Ethernet TX framer between two frame sources
//            (src0 = ARP reply, src1 = IPv4). Round-robin arbitration with
//            the grant held for a whole frame, header latching, registered
//            payload pass-through, inter-frame gap and silent-owner timeout.
// Ports    : TX_CLK / rst            - clock, synchronous active-high reset
//            srcN_req                - frame request (level)
//            srcN_dst_mac/len_type   - header fields, stable while req=1
//            srcN_data_v / srcN_data - payload octet stream
//            srcN_gnt                - source N owns the framer
//            tx_start                - one-cycle pulse, header outputs valid
//            tx_dst_mac/tx_len_type  - latched header to framer
//            tx_data_v / tx_data     - payload to framer (1-cycle latency)
//            tx_done                 - framer finished the frame (incl. FCS)
//            owner                   - current/last granted source index
//            arb_timeout_irq         - pulse when a grant is revoked by timeout
// Revision : 1.0 - initial release
// ============================================================================
module tx_ethernet_arbiter #(
    parameter int          OCT     = 8,
    parameter int          IFG_CYC = 12,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic             TX_CLK,
    input  logic             rst,
    input  logic             src0_req,
    input  logic [OCT*6-1:0] src0_dst_mac,
    input  logic [OCT*2-1:0] src0_len_type,
    input  logic             src0_data_v,
    input  logic [OCT-1:0]   src0_data,
    output logic             src0_gnt,
    input  logic             src1_req,
    input  logic [OCT*6-1:0] src1_dst_mac,
    input  logic [OCT*2-1:0] src1_len_type,
    input  logic             src1_data_v,
    input  logic [OCT-1:0]   src1_data,
    output logic             src1_gnt,
    output logic             tx_start,
    output logic [OCT*6-1:0] tx_dst_mac,
    output logic [OCT*2-1:0] tx_len_type,
    output logic             tx_data_v,
    output logic [OCT-1:0]   tx_data,
    input  logic             tx_done,
    output logic             owner,
    output logic             arb_timeout_irq
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2,
        IFG       = 2'd3
    } state_t;

    localparam logic [15:0] c_ifg_load  = 16'(IFG_CYC - 1);
    localparam logic [15:0] c_tout_last = TIMEOUT - 16'd1;

    state_t             r_state,       w_state_nxt;
    logic               r_ptr,         w_ptr_nxt;
    logic               r_seen,        w_seen_nxt;
    logic [15:0]        r_tout_cnt,    w_tout_cnt_nxt;
    logic [15:0]        r_ifg_cnt,     w_ifg_cnt_nxt;
    logic [1:0]         r_gnt,         w_gnt_nxt;
    logic               r_tx_start,    w_tx_start_nxt;
    logic [OCT*6-1:0]   r_tx_dst_mac,  w_tx_dst_mac_nxt;
    logic [OCT*2-1:0]   r_tx_len_type, w_tx_len_type_nxt;
    logic               r_tx_data_v,   w_tx_data_v_nxt;
    logic [OCT-1:0]     r_tx_data,     w_tx_data_nxt;
    logic               r_owner,       w_owner_nxt;
    logic               r_irq,         w_irq_nxt;

    logic               w_winner;
    logic               w_own_dv;
    logic [OCT-1:0]     w_own_data;

    // Pointer source wins if it requests, otherwise the other one does.
    // Only meaningful when at least one request is high.
    assign w_winner   = r_ptr ? src1_req : ~src0_req;
    assign w_own_dv   = r_owner ? src1_data_v : src0_data_v;
    assign w_own_data = r_owner ? src1_data   : src0_data;

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_seen_nxt        = r_seen;
        w_tout_cnt_nxt    = r_tout_cnt;
        w_ifg_cnt_nxt     = r_ifg_cnt;
        w_gnt_nxt         = r_gnt;
        w_tx_start_nxt    = 1'b0;
        w_tx_dst_mac_nxt  = r_tx_dst_mac;
        w_tx_len_type_nxt = r_tx_len_type;
        w_tx_data_v_nxt   = 1'b0;
        w_tx_data_nxt     = r_tx_data;
        w_owner_nxt       = r_owner;
        w_irq_nxt         = 1'b0;

        case (r_state)
            IDLE: begin
                if (src0_req || src1_req) begin
                    w_gnt_nxt         = w_winner ? 2'b10 : 2'b01;
                    w_tx_start_nxt    = 1'b1;
                    w_owner_nxt       = w_winner;
                    w_tx_dst_mac_nxt  = w_winner ? src1_dst_mac  : src0_dst_mac;
                    w_tx_len_type_nxt = w_winner ? src1_len_type : src0_len_type;
                    w_ptr_nxt         = ~w_winner;
                    w_seen_nxt        = 1'b0;
                    w_tout_cnt_nxt    = 16'd0;
                    w_state_nxt       = STREAM;
                end
            end

            STREAM: begin
                w_tx_data_v_nxt = w_own_dv;
                w_tx_data_nxt   = w_own_data;
                if (w_own_dv) begin
                    w_seen_nxt = 1'b1;
                end else if (r_seen) begin
                    // First gap after payload started marks the frame end.
                    w_gnt_nxt   = 2'b00;
                    w_state_nxt = WAIT_DONE;
                end else if (r_tout_cnt == c_tout_last) begin
                    // Owner never produced an octet: the framer was never
                    // started on payload, so no tx_done will come.
                    w_gnt_nxt     = 2'b00;
                    w_irq_nxt     = 1'b1;
                    w_ifg_cnt_nxt = c_ifg_load;
                    w_state_nxt   = IFG;
                end else begin
                    w_tout_cnt_nxt = r_tout_cnt + 16'd1;
                end
            end

            WAIT_DONE: begin
                if (tx_done) begin
                    w_ifg_cnt_nxt = c_ifg_load;
                    w_state_nxt   = IFG;
                end
            end

            IFG: begin
                if (r_ifg_cnt == 16'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ifg_cnt_nxt = r_ifg_cnt - 16'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= 1'b0;
            r_seen        <= 1'b0;
            r_tout_cnt    <= 16'd0;
            r_ifg_cnt     <= 16'd0;
            r_gnt         <= 2'b00;
            r_tx_start    <= 1'b0;
            r_tx_dst_mac  <= '0;
            r_tx_len_type <= '0;
            r_tx_data_v   <= 1'b0;
            r_tx_data     <= '0;
            r_owner       <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_seen        <= w_seen_nxt;
            r_tout_cnt    <= w_tout_cnt_nxt;
            r_ifg_cnt     <= w_ifg_cnt_nxt;
            r_gnt         <= w_gnt_nxt;
            r_tx_start    <= w_tx_start_nxt;
            r_tx_dst_mac  <= w_tx_dst_mac_nxt;
            r_tx_len_type <= w_tx_len_type_nxt;
            r_tx_data_v   <= w_tx_data_v_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_owner       <= w_owner_nxt;
            r_irq         <= w_irq_nxt;
        end
    end

    assign src0_gnt        = r_gnt[0];
    assign src1_gnt        = r_gnt[1];
    assign tx_start        = r_tx_start;
    assign tx_dst_mac      = r_tx_dst_mac;
    assign tx_len_type     = r_tx_len_type;
    assign tx_data_v       = r_tx_data_v;
    assign tx_data         = r_tx_data;
    assign owner           = r_owner;
    assign arb_timeout_irq = r_irq;

endmodule
`default_nettype wire

// File: doc/tx_ethernet_arbiter.md
Name: tx_ethernet_arbiter

Overview:
Shares the single Ethernet transmit framer between two upper-layer frame sources: src0 (ARP reply) and src1 (IPv4).
- Arbitrates round-robin and holds the grant for the whole frame.
- Forwards the header fields and the octet stream to the framer.
- Enforces the inter-frame gap after the framer reports completion.
- Sits between the protocol layers and the GMII transmit framer in the TX_CLK domain.

Parameters:
OCT, 8, octet width in bits
IFG_CYC, 12, idle cycles enforced after tx_done before the next grant
TIMEOUT, 16'd1024, cycles a granted source may stay silent (no data_v) before the grant is revoked

Ports:
TX_CLK  in  1  transmit clock; the only clock
rst  in  1  synchronous, active-high reset
src0_req  in  1  src0 requests a frame; level
src0_dst_mac  in  OCT*6  src0 destination MAC; stable while src0_req=1
src0_len_type  in  OCT*2  src0 EtherType
src0_data_v  in  1  src0 payload octet valid
src0_data  in  OCT  src0 payload octet
src0_gnt  out  1  src0 owns the framer
src1_req, src1_dst_mac, src1_len_type, src1_data_v, src1_data, src1_gnt  -  same as src0, for src1
tx_start  out  1  one-cycle pulse; header outputs valid
tx_dst_mac  out  OCT*6  latched destination MAC
tx_len_type  out  OCT*2  latched EtherType
tx_data_v  out  1  payload valid to framer
tx_data  out  OCT  payload octet to framer
tx_done  in  1  framer pulse: last octet (incl. FCS) sent
owner  out  1  index of the current/last granted source
arb_timeout_irq  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
Reset: all outputs are 0; state=IDLE; round-robin pointer ptr=0; counters=0. Reset mid-frame takes effect at the next edge and drops the grant immediately. The framer is not notified; the bench must also reset it.

States: IDLE, STREAM, WAIT_DONE, IFG.

IDLE:
- If any req is high at edge T, pick a winner: src[ptr] if it requests, else the other source.
- At T+1: winner gnt=1, tx_start=1 (one cycle), owner=winner, tx_dst_mac/tx_len_type latched from the winner's inputs at T.
- At the same edge: ptr <= ~winner, seen=0, tout_cnt=0, state <= STREAM.
- A req that drops before being sampled is ignored.

STREAM:
- Registered pass-through with one-cycle latency: tx_data_v <= data_v of owner; tx_data <= data of owner.
- Non-owner data_v/data are ignored.
- data_v=1 sets seen=1.
- seen=1 and data_v=0: gnt <= 0, tx_data_v <= 0, state <= WAIT_DONE.
- seen=0: tout_cnt increments each cycle. When tout_cnt == TIMEOUT-1: gnt <= 0, arb_timeout_irq pulse, state <= IFG (no tx_done expected), ifg_cnt <= IFG_CYC-1.
- Owner req deassertion is ignored; the frame end is defined only by the data_v falling edge.
- data_v gaps after the first octet end the frame. Sources must stream contiguously.

WAIT_DONE:
- Wait for tx_done=1, then ifg_cnt <= IFG_CYC-1, state <= IFG.
- tx_done arriving in any other state is ignored.

IFG:
- ifg_cnt decrements each cycle. At 0, state <= IDLE.
- The earliest new grant is IFG_CYC+1 cycles after the tx_done cycle.

Fairness: both sources requesting continuously alternate grants 0,1,0,1,…

Widths: tout_cnt and ifg_cnt are 16 bits, with no wrap at the stated defaults.

Test Plan:
- Only src0_req=1, dst_mac=48'h0011_2233_4455, len_type=16'h0806, 4 octets AA,BB,CC,DD -> src0_gnt and tx_start one cycle after req; tx_dst_mac/tx_len_type match; tx_data AA..DD each one cycle after the source drives it; gnt falls the cycle after data_v falls.
- tx_done pulsed 3 cycles after frame end, src1_req held high -> src1_gnt/tx_start exactly 13 cycles after the tx_done cycle (IFG_CYC=12).
- src0_req and src1_req both high from reset, 5 frames -> owner sequence 0,1,0,1,0; never both gnt high.
- src1 granted, never asserts data_v -> src1_gnt falls after 1024 cycles; arb_timeout_irq one-cycle pulse; src0 (requesting) granted 13 cycles later; no tx_data_v seen.
- src0 asserts src0_data_v while src1 owns the frame -> no effect on tx_data/tx_data_v; src1's octets pass intact.
- rst asserted mid-STREAM for 1 cycle -> next edge: all gnt, tx_data_v, tx_start, owner=0; src1 requesting -> granted before src0 would be (ptr=0 so src0 wins if both request; verify src0 wins when both high).
